// File: rtl/hazard_pipe_regs.sv
// hazard_pipe_regs: PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB
// control/address pipeline registers. It applies the hazard unit's stall and
// flush requests, and returns stage-tagged register addresses and
// write-enables to the hazard unit.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// event counters (StallCount, FlushCount).
module hazard_pipe_regs #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic [XLEN-1:0] PCNextF,
  input  logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            ResultSrcE0,
  output logic            ValidE,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]     StallCount,
  output logic [31:0]     FlushCount
`endif
);

  // PC register: holds while fetch is stalled, otherwise follows the PC mux
  always_ff @(posedge clk) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= PCNextF;
    end
  end

  // IF/ID: a flush beats a stall, because the older branch squashes the younger instruction
  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      InstrD <= NOP_INSTR;
      PCD    <= '0;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      InstrD <= InstrF;
      PCD    <= PCF;
      ValidD <= 1'b1;
    end
  end

  // ID/EX: no stall input; a bubble clears every address so it can never match a forward
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      Rs1E       <= '0;
      Rs2E       <= '0;
      RdE        <= '0;
      RegWriteE  <= 1'b0;
      MemWriteE  <= 1'b0;
      ResultSrcE <= '0;
      ValidE     <= 1'b0;
    end else begin
      Rs1E       <= Rs1D;
      Rs2E       <= Rs2D;
      RdE        <= RdD;
      RegWriteE  <= RegWriteD;
      MemWriteE  <= MemWriteD;
      ResultSrcE <= ResultSrcD;
      ValidE     <= ValidD;
    end
  end

  // EX/MEM: advances unconditionally every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
    end else begin
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
    end
  end

  // MEM/WB: advances unconditionally every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else begin
      RdW        <= RdM;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
    end
  end

  // Load-in-E flag goes straight from the ID/EX register to the hazard unit
  assign ResultSrcE0 = ResultSrcE[0];

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters: stall cycles, and cycles with any flush request
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != 32'hFFFF_FFFF)) begin
        StallCount <= StallCount + 32'd1;
      end
      if ((FlushD || FlushE) && (FlushCount != 32'hFFFF_FFFF)) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// tb_hazard_pipe_regs: directed test-plan sequences followed by randomized
// stall/flush/reset traffic, compared every cycle against a packet-level
// reference model of the pipeline.
module tb_hazard_pipe_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF;
  logic [31:0] PCF, InstrD, PCD;
  logic        ValidD;
  logic        RegWriteD, MemWriteD;
  logic [1:0]  ResultSrcD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic        ResultSrcE0, ValidE;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int checks = 0;
  int errors = 0;

  // One instruction's control/address bundle as it moves E -> M -> W
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
    logic       valid;
  } pkt_t;

  // Reference model state: fetch PC, decode slot, and packets in E/M/W
  logic [31:0] mPCF, mInstrD, mPCD;
  logic        mValidD;
  pkt_t        mStage [3];
  logic [31:0] mStallCount, mFlushCount;

  hazard_pipe_regs dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ResultSrcE0(ResultSrcE0), .ValidE(ValidE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advances the reference model by one clock using the inputs currently applied
  task automatic modelStep();
    pkt_t fromD;
    if (rst) begin
      mPCF = 32'h0000_0000;
      mInstrD = 32'h0000_0013;
      mPCD = '0;
      mValidD = 1'b0;
      for (int i = 0; i < 3; i++) mStage[i] = '0;
      mStallCount = '0;
      mFlushCount = '0;
      return;
    end
    if (StallD && mStallCount != 32'hFFFF_FFFF) mStallCount++;
    if ((FlushD || FlushE) && mFlushCount != 32'hFFFF_FFFF) mFlushCount++;
    fromD = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, regWrite: RegWriteD, memWrite: MemWriteD,
              resultSrc: ResultSrcD, valid: mValidD};
    mStage[2] = mStage[1];
    mStage[1] = mStage[0];
    mStage[0] = FlushE ? pkt_t'('0) : fromD;
    if (FlushD) begin
      mInstrD = 32'h0000_0013;
      mPCD = '0;
      mValidD = 1'b0;
    end else if (!StallD) begin
      mInstrD = InstrF;
      mPCD = mPCF;
      mValidD = 1'b1;
    end
    if (!StallF) mPCF = PCNextF;
  endtask

  // Compares every DUT output against the model
  task automatic checkAll();
    checkOutput("PCF", PCF, mPCF);
    checkOutput("InstrD", InstrD, mInstrD);
    checkOutput("PCD", PCD, mPCD);
    checkOutput("ValidD", 32'(ValidD), 32'(mValidD));
    checkOutput("Rs1E", 32'(Rs1E), 32'(mStage[0].rs1));
    checkOutput("Rs2E", 32'(Rs2E), 32'(mStage[0].rs2));
    checkOutput("RdE", 32'(RdE), 32'(mStage[0].rd));
    checkOutput("RegWriteE", 32'(RegWriteE), 32'(mStage[0].regWrite));
    checkOutput("MemWriteE", 32'(MemWriteE), 32'(mStage[0].memWrite));
    checkOutput("ResultSrcE", 32'(ResultSrcE), 32'(mStage[0].resultSrc));
    checkOutput("ResultSrcE0", 32'(ResultSrcE0), 32'(mStage[0].resultSrc[0]));
    checkOutput("ValidE", 32'(ValidE), 32'(mStage[0].valid));
    checkOutput("RdM", 32'(RdM), 32'(mStage[1].rd));
    checkOutput("RegWriteM", 32'(RegWriteM), 32'(mStage[1].regWrite));
    checkOutput("MemWriteM", 32'(MemWriteM), 32'(mStage[1].memWrite));
    checkOutput("ResultSrcM", 32'(ResultSrcM), 32'(mStage[1].resultSrc));
    checkOutput("RdW", 32'(RdW), 32'(mStage[2].rd));
    checkOutput("RegWriteW", 32'(RegWriteW), 32'(mStage[2].regWrite));
    checkOutput("ResultSrcW", 32'(ResultSrcW), 32'(mStage[2].resultSrc));
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("StallCount", StallCount, mStallCount);
    checkOutput("FlushCount", FlushCount, mFlushCount);
`endif
  endtask

  // Clocks the applied inputs in, steps the model, then checks 1 time unit after the edge
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  // Sets the hazard controls in one call
  task automatic setHazard(input logic sf, input logic sd, input logic fd, input logic fe);
    StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
  endtask

  // Randomizes the datapath-side inputs
  task automatic randomData();
    PCNextF = $urandom;
    InstrF = $urandom;
    RegWriteD = 1'($urandom_range(0, 1));
    MemWriteD = 1'($urandom_range(0, 1));
    ResultSrcD = 2'($urandom_range(0, 3));
    Rs1D = 5'($urandom_range(0, 31));
    Rs2D = 5'($urandom_range(0, 31));
    RdD = 5'($urandom_range(0, 31));
  endtask

  initial begin
    rst = 1'b1;
    setHazard(1'b1, 1'b0, 1'b0, 1'b1);
    randomData();

    // Reset held two cycles with stall/flush active
    repeat (2) applyStimulus();
    checkOutput("rstPCF", PCF, 32'h0);
    checkOutput("rstInstrD", InstrD, 32'h0000_0013);
    checkOutput("rstValidE", 32'(ValidE), 32'h0);

    // Free run: RdD=5 with RegWriteD=1 travels E, M, W on consecutive cycles
    rst = 1'b0;
    setHazard(1'b0, 1'b0, 1'b0, 1'b0);
    RdD = 5'd5; RegWriteD = 1'b1; MemWriteD = 1'b0; ResultSrcD = 2'd0;
    Rs1D = 5'd1; Rs2D = 5'd2;
    PCNextF = 32'h4; InstrF = 32'h0050_0293;
    applyStimulus();
    checkOutput("runRdE", 32'(RdE), 32'd5);
    PCNextF = 32'h8; InstrF = 32'h0010_8113;
    applyStimulus();
    checkOutput("runRdM", 32'(RdM), 32'd5);
    checkOutput("runPCF", PCF, 32'h8);

    // Load-use stall at PCF=0x8
    setHazard(1'b1, 1'b1, 1'b0, 1'b1);
    PCNextF = 32'hC; InstrF = 32'h0031_8193; RdD = 5'd7;
    applyStimulus();
    checkOutput("stallPCF", PCF, 32'h8);
    checkOutput("stallInstrD", InstrD, 32'h0010_8113);
    checkOutput("stallRdE", 32'(RdE), 32'd0);
    checkOutput("stallRdW", 32'(RdW), 32'd5);
    checkOutput("stallRegWriteW", 32'(RegWriteW), 32'd1);

    // Branch flush
    setHazard(1'b0, 1'b0, 1'b1, 1'b1);
    MemWriteD = 1'b1;
    applyStimulus();
    checkOutput("flushInstrD", InstrD, 32'h0000_0013);
    checkOutput("flushValidD", 32'(ValidD), 32'd0);
    checkOutput("flushMemWriteE", 32'(MemWriteE), 32'd0);

    // Stall and flush together: flush wins
    setHazard(1'b0, 1'b0, 1'b0, 1'b0);
    PCNextF = 32'h10; InstrF = 32'h0040_0213;
    applyStimulus();
    setHazard(1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus();
    checkOutput("bothValidD", 32'(ValidD), 32'd0);
    checkOutput("bothInstrD", InstrD, 32'h0000_0013);

    // Randomized traffic with occasional mid-run reset
    for (int n = 0; n < 400; n++) begin
      randomData();
      rst = ($urandom_range(0, 49) == 0);
      setHazard(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
      applyStimulus();
    end

    $display("[TB] random phase complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_pipe_regs.md
Name: hazard_pipe_regs

Overview:
- Consumer side of the hazard interface. Holds the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB control/address pipeline registers.
- Applies StallF, StallD, FlushD and FlushE each cycle.
- Sends the stage-tagged register addresses and write-enables back to the hazard unit: Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE0.
- Sits between the fetch/decode datapath and the hazard unit. Datapath operand and result buses are out of scope.

Parameters:
- XLEN, 32, PC and instruction width
- RESET_PC, 32'h0000_0000, PCF value after reset
- NOP_INSTR, 32'h0000_0013, instruction injected into InstrD on reset or flush (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- StallF  in  1  hold PC register
- StallD  in  1  hold IF/ID register
- FlushD  in  1  bubble IF/ID
- FlushE  in  1  bubble ID/EX
- PCNextF  in  XLEN  next PC from the PC mux
- InstrF  in  XLEN  fetched instruction
- PCF  out  XLEN  current fetch PC
- InstrD  out  XLEN  decode-stage instruction
- PCD  out  XLEN  decode-stage PC
- ValidD  out  1  IF/ID holds a real instruction
- RegWriteD, MemWriteD  in  1  decoded controls
- ResultSrcD  in  2  decoded result select
- Rs1D, Rs2D, RdD  in  5  decoded register addresses
- Rs1E, Rs2E, RdE  out  5  ID/EX register addresses
- RegWriteE, MemWriteE  out  1  ID/EX controls
- ResultSrcE  out  2  ID/EX result select
- ResultSrcE0  out  1  ResultSrcE[0], load-in-E flag to the hazard unit
- ValidE  out  1  ID/EX holds a real instruction
- RdM  out  5  EX/MEM destination
- RegWriteM, MemWriteM  out  1  EX/MEM controls
- ResultSrcM  out  2  EX/MEM result select
- RdW  out  5  MEM/WB destination
- RegWriteW  out  1  MEM/WB write enable
- ResultSrcW  out  2  MEM/WB result select

Behaviour:
- All registers update on posedge clk. rst takes priority over every other input.
- Reset values:
  - PCF = RESET_PC
  - InstrD = NOP_INSTR, PCD = 0, ValidD = 0
  - All E/M/W fields = 0, ValidE = 0
- PC register:
  - StallF=1: PCF holds.
  - Otherwise PCF <= PCNextF.
- IF/ID, priority FlushD > StallD > load:
  - FlushD=1: InstrD <= NOP_INSTR, PCD <= 0, ValidD <= 0.
  - StallD=1 (FlushD=0): hold all fields.
  - Otherwise: InstrD <= InstrF, PCD <= PCF, ValidD <= 1.
  - FlushD and StallD both high (load-use stall coinciding with a taken branch): flush wins. The branch in E is older and squashes the younger instruction.
- ID/EX:
  - FlushE=1: Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, ResultSrcE and ValidE all <= 0. The bubble must never produce a write or a forward match on a nonzero register.
  - Otherwise: load the D-side inputs; ValidE <= ValidD.
  - ID/EX has no stall input. A stall always arrives with FlushE, so E receives a bubble.
- EX/MEM and MEM/WB:
  - Never stall or flush; advance unconditionally every cycle.
  - M fields <= E fields; W fields <= M fields.
- ResultSrcE0 is combinational from the ResultSrcE register; zero latency.
- Latency: a non-stalled, non-flushed instruction reaches D one cycle after fetch, then E, M and W on each following cycle.
- Reset asserted mid-operation: every stage is cleared on that edge regardless of stall or flush inputs.
- Rd/Rs address 0 passes through unchanged. Suppressing x0 forwarding is the hazard unit's job, not this block's.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds two outputs:
  - StallCount (32): increments once per cycle with StallD=1.
  - FlushCount (32): increments once per cycle with FlushD=1 or FlushE=1.
- Both counters saturate at 32'hFFFF_FFFF, reset to 0 on rst, and count only after reset deassertion.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with StallF=1 and FlushE=1 -> PCF=0, InstrD=0x00000013, ValidD=0, ValidE=0, RegWriteW=0.
- Free run: PCNextF=0x4, 0x8, 0xC with distinct InstrF; RdD=5, RegWriteD=1 -> RdE=5 one cycle after RdD presented, RdM=5 next cycle, RdW=5 after that; RegWriteW=1.
- Load-use stall: StallF=StallD=FlushE=1 for one cycle with PCF=0x8 -> PCF stays 0x8, InstrD held, ValidE=0 and RdE=0 next cycle; M/W keep advancing.
- Branch flush: FlushD=FlushE=1 -> next cycle InstrD=0x00000013, ValidD=0, RegWriteE=0, MemWriteE=0.
- Stall and flush together: StallD=1, FlushD=1 -> IF/ID flushed (ValidD=0), not held.
- Perf counters (HAZARD_PERF_CNT_EN defined): 3 stall cycles, 2 flush cycles -> StallCount=3, FlushCount=5 (stall cycles assert FlushE); preload near max -> saturates at 0xFFFFFFFF.
